// File: rtl/door_input_conditioner.sv
// door_input_conditioner
//   Synchronizes and debounces four door contacts, produces per-channel
//   debounced level plus one-cycle rise/fall pulses, and derives one-cycle
//   open/close commands for the downstream door FSM.
//
// Ports
//   clk        : design clock, rising edge
//   rst        : asynchronous active-high reset
//   ena        : conditioning enable (synchronizers always run)
//   raw_in     : [0] open btn, [1] close btn, [2] obstacle, [3] fully-open limit
//   level_out  : debounced level per channel
//   rise_out   : one-cycle pulse on debounced 0->1
//   fall_out   : one-cycle pulse on debounced 1->0
//   open_req   : one-cycle open command
//   close_req  : one-cycle close command
module door_input_conditioner #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] raw_in,
  output logic [3:0] level_out,
  output logic [3:0] rise_out,
  output logic [3:0] fall_out,
  output logic       open_req,
  output logic       close_req
);

  localparam int NCH = 4;
  localparam int CW  = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic [NCH-1:0]         r_s1, r_s2;
  logic [NCH-1:0][CW-1:0] r_cnt;
  logic [NCH-1:0]         r_level, r_rise, r_fall;
  logic                   r_open, r_close;

  logic [NCH-1:0]         w_accept, w_rise, w_fall;
  logic                   w_open, w_close;

  // Two-flop synchronizer, free-running regardless of ena.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= raw_in;
      r_s2 <= r_s1;
    end
  end

  // A channel is accepted on the edge where it has already seen
  // DEB_CYCLES-1 consecutive differing samples and still differs.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NCH; i++)
      w_accept[i] = ena && (r_s2[i] != r_level[i]) && (r_cnt[i] == CMAX);
  end

  assign w_rise  = w_accept & r_s2;
  assign w_fall  = w_accept & ~r_s2;
  // Obstacle appearing always reopens; open beats close. The obstacle level
  // used to block close is the pre-update value, so a close press while the
  // obstacle is present is simply dropped.
  assign w_open  = w_rise[0] | w_rise[2];
  assign w_close = w_rise[1] & ~r_level[2] & ~w_open;

  // Debounce counters and accepted levels; both hold while ena=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= '0;
    end else if (ena) begin
      for (int i = 0; i < NCH; i++) begin
        if (r_s2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CMAX) begin
          r_cnt[i]   <= '0;
          r_level[i] <= r_s2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered pulses; w_accept already includes ena, so they clear when
  // disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise  <= '0;
      r_fall  <= '0;
      r_open  <= 1'b0;
      r_close <= 1'b0;
    end else begin
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_open  <= w_open;
      r_close <= w_close;
    end
  end

  assign level_out = r_level;
  assign rise_out  = r_rise;
  assign fall_out  = r_fall;
  assign open_req  = r_open;
  assign close_req = r_close;

endmodule

// File: doc/door_input_conditioner.md
DOOR_INPUT_CONDITIONER -- requirements
Module: door_input_conditioner

Interface
REQ-001 Parameter: DEB_CYCLES, default 16, consecutive clean samples required to accept a new input level (legal range 2..255).
REQ-002 Port: clk  input  1  single design clock, all flops rising-edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: ena  input  1  conditioning enable.
REQ-005 Port: raw_in  input  4  raw contacts: [0] open button, [1] close button, [2] obstacle sensor, [3] fully-open limit switch.
REQ-006 Port: level_out  output  4  debounced level per channel.
REQ-007 Port: rise_out  output  4  one-cycle pulse on debounced 0->1 per channel.
REQ-008 Port: fall_out  output  4  one-cycle pulse on debounced 1->0 per channel.
REQ-009 Port: open_req  output  1  one-cycle open command to the downstream door FSM.
REQ-010 Port: close_req  output  1  one-cycle close command to the downstream door FSM.
REQ-011 One clock and one reset only; reset is asynchronous and active-high; no other clock or reset input exists.

Function
REQ-012 Each channel passes through a 2-flop synchronizer (s1, s2), always clocked regardless of ena.
REQ-013 Each channel has a counter, width $clog2(DEB_CYCLES+1), compared against s2 and level_out.
REQ-014 Edge with ena=1 and s2==level: counter cleared to 0.
REQ-015 Edge with ena=1 and s2!=level, counter<DEB_CYCLES-1: counter increments.
REQ-016 Edge with ena=1 and s2!=level, counter==DEB_CYCLES-1: level toggles to s2, counter cleared, matching rise/fall bit set for exactly that one cycle.
REQ-017 Latency: raw change held steady before edge 1 appears on level_out after edge DEB_CYCLES+2.
REQ-018 Any bounce back to the current level before acceptance clears the counter; acceptance timing restarts from the last transition.
REQ-019 rise_out/fall_out are registered, asserted the same cycle level_out changes, deasserted the next edge; never both high on one channel.
REQ-020 open_req (registered, same cycle as rise) = rise[0] OR rise[2]; obstacle appearing always forces reopen.
REQ-021 close_req = rise[1] AND NOT level[2] (pre-update value) AND NOT open_req; open wins simultaneous requests.
REQ-022 A close press during obstacle is dropped, not queued; no close_req when the obstacle clears later.
REQ-023 Channel [3] only produces level/rise/fall; it never generates open_req or close_req.
REQ-024 Edge with ena=0: counters and level_out hold, rise_out, fall_out, open_req, close_req forced 0 next edge; counting resumes from held value when ena returns to 1.
REQ-025 Channels are independent; simultaneous acceptance on several channels in one cycle is legal and each produces its own pulse.

Reset
REQ-026 rst=1 immediately (asynchronously) clears s1, s2, counters, level_out, rise_out, fall_out, open_req, close_req to 0.
REQ-027 Reset mid-count discards partial count; after release an input already high is accepted DEB_CYCLES+2 edges later with a rise pulse.
REQ-028 No output glitches or pulses while rst is held.

Verification (bench DEB_CYCLES=4, ena=1 unless stated)
REQ-029 raw_in[0] 0->1 held before edge 1 -> level_out[0]=1, rise_out[0]=1, open_req=1 after edge 6, all pulses 0 after edge 7.
REQ-030 raw_in[1] toggles 1,0,1,0 on edges 1-4 then held 1 from edge 5 -> exactly one rise_out[1], seen after edge 10; close_req=1 that cycle.
REQ-031 raw_in[2]=1 accepted, then raw_in[1] pressed -> rise_out[1] pulses, close_req stays 0; later raw_in[2]->0 gives fall_out[2], close_req still 0.
REQ-032 raw_in[0] and raw_in[1] rise on the same edge -> open_req=1, close_req=0, rise_out=4'b0011 in one cycle.
REQ-033 raw_in[3] rises, ena=0 for 5 cycles after 2 counting edges -> level_out[3] frozen at 0; ena=1 -> acceptance after 2 more edges, no open/close request.
REQ-034 rst pulsed mid-count on raw_in[0] -> all outputs 0 within the reset cycle; with raw_in[0] still 1, acceptance 6 edges after rst release.
